square_dds_ctrl: RTL

SQUARE_DDS_CTRL -- requirements
Module: square_dds_ctrl

---
 rtl/square_dds_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/square_dds_ctrl.sv
// square_dds_ctrl: run/burst sequencer and shadowed settings for a square-wave DDS.
// Active settings change only in IDLE or on a 1x rising edge, followed by a 2-cycle reload gap.
module square_dds_ctrl #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] burst_len,
    input  logic        square_1x_in,
    output logic        out_en,
    output logic [31:0] freq_square_1x,
    output logic [31:0] freq_square_2x,
    output logic [31:0] phase_square_1x,
    output logic [31:0] phase_square_2x,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);
    localparam logic [31:0] FMAX = 32'(CLK_FREQ / 2);
    localparam logic [31:0] PMAX = 32'(CLK_FREQ - 1);
    typedef enum logic [1:0] {IDLE, RUN, RELOAD} state_t;
    state_t state_q, state_d;
    logic [3:0][31:0] shadow_q, shadow_d, active_q, active_d;
    logic [15:0] cnt_q, cnt_d;
    logic pend_q, pend_d, rl_q, rl_d, sq_q, done_d;
    logic out_en_q, busy_q, ready_q, done_q, err_q;
    logic accept, commit, bad, edge_det, term;
    always_comb begin
        accept   = cfg_valid && ready_q;
        commit   = accept && cfg_addr == 3'd4;
        bad      = accept && (cfg_addr[2] ? cfg_addr != 3'd4 : cfg_data > (cfg_addr[1] ? PMAX : FMAX));
        edge_det = square_1x_in && !sq_q;
        term     = burst_len != 16'd0 && cnt_q == burst_len;
        shadow_d = shadow_q;
        if (accept && !cfg_addr[2] && !bad) shadow_d[cfg_addr[1:0]] = cfg_data;
        active_d = active_q;
        pend_d   = pend_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        rl_d     = rl_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q || commit) begin
                    active_d = shadow_q;
                    pend_d   = 1'b0;
                end
                if (start && !stop) begin
                    state_d = RUN;
                    cnt_d   = 16'd0;
                end
            end
            RUN: begin
                if (stop) state_d = IDLE;
                else if (edge_det && term) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (edge_det) begin
                    cnt_d = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
                    if (pend_q) begin
                        active_d = shadow_q;
                        pend_d   = 1'b0;
                        state_d  = RELOAD;
                        rl_d     = 1'b0;
                    end
                end
            end
            RELOAD: begin
                if (stop) state_d = IDLE;
                else if (rl_q) state_d = RUN;
                else rl_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // a commit landing on a reload edge re-arms for the next edge
        if (commit && state_q == RUN) pend_d = 1'b1;
    end
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            rl_q     <= 1'b0;
            sq_q     <= 1'b0;
            out_en_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            rl_q     <= rl_d;
            sq_q     <= square_1x_in;
            out_en_q <= state_d == RUN;
            busy_q   <= state_d != IDLE;
            ready_q  <= state_d != RELOAD;
            done_q   <= done_d;
            err_q    <= bad;
        end
    end
    assign cfg_ready       = ready_q;
    assign out_en          = out_en_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign cfg_err         = err_q;
    assign freq_square_1x  = active_q[0];
    assign freq_square_2x  = active_q[1];
    assign phase_square_1x = active_q[2];
    assign phase_square_2x = active_q[3];
endmodule
